spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command/register controller sitting behind the SPI slave byte interface. It frames each `ss`-delimited transaction into a command byte followed by data bytes, and performs auto-incrementing reads and writes on an internal bank of NREGS 8-bit configuration registers. Written values are exported to the rest of the chip, and read data is fed back onto the SPI slave's `dout`. It is the block that sequences the SPI shifter and turns it into a register-access port.

## Interface
- NREGS, 8: number of R/W registers (1..127), at addresses 0..NREGS-1
- RST_VAL, 8'h00: reset value of every register
- clk  input  1  system clock; all logic on posedge
- rst  input  1  asynchronous, active-low reset
- ss  input  1  SPI slave select, synchronous to clk; 1 = idle/abort
- spi_din  input  8  byte received from SPI slave (`din` of shifter)
- spi_done  input  1  1-cycle pulse: spi_din holds a new byte
- spi_dout  output  8  byte to transmit on next SPI byte (`dout` of shifter)
- status_i  input  8  status byte returned during the command byte
- regs_o  output  8*NREGS  flattened register bank; reg k at [8k+7:8k]
- wr_stb  output  1  1-cycle pulse per committed register write
- wr_addr  output  7  address of write on wr_stb
- wr_data  output  8  data of write on wr_stb
- busy  output  1  1 while a transaction is framed (state != IDLE)

## Operation
- States: IDLE, CMD, WR, RD.
- IDLE: entered on reset and whenever ss=1. ss=0 -> CMD next cycle.
- CMD: first spi_done after ss falls. Byte = {rw, addr[6:0]}; rw=1 write, rw=0 read. Latch addr into ptr. rw=1 -> WR, rw=0 -> RD.
- WR: each spi_done writes spi_din to reg[ptr] if ptr < NREGS, else it is discarded (no wr_stb). Then ptr <= ptr+1.
- RD: each spi_done is a dummy byte from the master. ptr <= ptr+1, and spi_dout is reloaded with the next read value.
- Read value: reg[ptr] if ptr < NREGS, else 8'h00.
- ptr is 7 bits and wraps 7'h7F -> 7'h00. Out-of-range addresses follow the rules above even after a wrap.
- spi_dout sources:
  - IDLE/CMD: status_i, registered every cycle.
  - Cycle after the CMD byte with rw=0: reg[addr].
  - After each RD byte: value at ptr+1.
  - WR: holds 8'h00.
- ss=1 in any state -> IDLE next cycle, ptr unchanged but meaningless. If ss=1 and spi_done occur in the same cycle, ss wins: the byte is dropped and no write occurs.
- spi_done in IDLE is ignored.

## Timing
- Reset (rst=0, async):
  - State is IDLE and ptr is 0.
  - All regs = RST_VAL.
  - spi_dout = 8'h00, wr_stb = 0, wr_addr = 0, wr_data = 0, busy = 0.
- All outputs are registered.
- Write latency: spi_done at cycle n -> wr_stb=1, wr_addr, wr_data valid and regs_o updated at cycle n+1.
- Read latency: spi_done at cycle n -> spi_dout valid at n+1. The SPI shifter samples spi_dout no earlier than the first sck edge of the next byte, which is at least 2 clk cycles after done.
- busy rises the cycle after ss falls and drops the cycle after ss rises.
- Back-to-back spi_done on consecutive cycles must be handled with no loss. This does not occur with real SPI, but the bench drives it.

## Structure
- Package spi_pkg:
  - typedef enum logic [1:0] {IDLE, CMD, WR, RD} spi_state_t
  - localparam CMD_WRITE_BIT = 7
  - localparam ADDR_W = 7
- One sub-module, spi_regbank:
  - NREGS x 8 register array with async active-low reset to RST_VAL.
  - Write port (we, addr, data) and combinational read port returning 8'h00 for out-of-range addresses.
- spi_reg_ctrl holds the FSM, ptr, dout mux and strobe registers.

## Test plan
- Write burst: ss=0, bytes 0x81, 0x12, 0x34, ss=1 -> reg1=0x12, reg2=0x34, two wr_stb pulses (addr 1, 2), other regs = RST_VAL.
- Read burst: regs preloaded 0x12/0x34 at 1/2; bytes 0x01, 0xFF, 0xFF -> spi_dout = status_i during cmd, then 0x12 one cycle after cmd done, 0x34 after 1st dummy.
- Out of range (NREGS=8): write 0x86, 0xAA, 0xBB, 0xCC -> reg6=0xAA, reg7=0xBB, no write or wr_stb for address 8; a read from 0x08 returns 0x00.
- Wrap: write 0xFF, 0x55, 0x66 -> address 0x7F dropped, ptr wraps, reg0=0x66, exactly one wr_stb (addr 0).
- Abort: ss rises in the same cycle as spi_done of data byte 0x77 during WR -> no write, IDLE next cycle, next transaction decodes a fresh command.
- Async reset mid-WR: rst=0 between two clk edges -> regs_o all RST_VAL and spi_dout=0x00 immediately, busy=0, and normal writes resume after rst=1 with a new ss cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package spi_pkg;

  // Transaction framing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } spi_state_t;

  // Bit of the command byte selecting write (1) or read (0).
  localparam int CMD_WRITE_BIT = 7;

  // Register pointer / address width; the pointer wraps at 2**ADDR_W.
  localparam int ADDR_W = 7;

endpackage

// File: rtl/spi_regbank.sv
// NREGS x 8-bit configuration register array, single write port, combinational read port.
// Latency: write lands one cycle after we_i; read is combinational.
// Backpressure: none; always accepts writes, out-of-range accesses are harmless.
//
// Ports:
//   clk, rst        clock and async active-low reset (regs -> RST_VAL)
//   we_i/waddr_i/wdata_i   write port; out-of-range addresses are ignored
//   raddr_i/rdata_o        read port; out-of-range addresses read as 8'h00
//   regs_o          flattened register bank, reg k at [8k+7:8k]
module spi_regbank
  import spi_pkg::*;
#(
  parameter int         NREGS   = 8,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [7:0]           rdata_o,
  output logic [8*NREGS-1:0]   regs_o
);

  logic [7:0] mem_q [NREGS];

  // Address decode by comparison keeps index widths independent of NREGS
  // and makes out-of-range addresses fall through naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= RST_VAL;
      end
    end else if (we_i) begin
      for (int k = 0; k < NREGS; k++) begin
        if (waddr_i == ADDR_W'(k)) begin
          mem_q[k] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if (raddr_i == ADDR_W'(k)) begin
        rdata_o = mem_q[k];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frames ss-delimited SPI byte streams into {rw,addr} command + auto-incrementing register accesses.
// Latency: write strobe / regs_o update and next read byte on spi_dout one cycle after spi_done.
// Backpressure: none; accepts one byte per cycle, ss=1 aborts and drops a coincident byte.
//
// Ports:
//   clk, rst            clock and async active-low reset
//   ss                  slave select (1 = idle/abort), synchronous to clk
//   spi_din/spi_done    received byte and its 1-cycle valid pulse
//   spi_dout            byte the shifter transmits next
//   status_i            status byte returned while the command byte shifts
//   regs_o              flattened register bank
//   wr_stb/wr_addr/wr_data  committed-write notification
//   busy                high while a transaction is framed
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int         NREGS   = 8,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic [7:0]           spi_din,
  input  logic                 spi_done,
  output logic [7:0]           spi_dout,
  input  logic [7:0]           status_i,
  output logic [8*NREGS-1:0]   regs_o,
  output logic                 wr_stb,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NREGS);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  spi_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q;

  logic              byte_vld;
  logic              ptr_in_range;
  logic              bank_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  // A byte arriving together with ss=1 belongs to an aborted transaction.
  assign byte_vld     = spi_done && !ss;
  assign ptr_in_range = (ptr_q < NREGS_A);

  spi_regbank #(
    .NREGS   (NREGS),
    .RST_VAL (RST_VAL)
  ) u_regbank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bank_we),
    .waddr_i (ptr_q),
    .wdata_i (spi_din),
    .raddr_i (rd_addr),
    .rdata_o (rd_data),
    .regs_o  (regs_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      dout_q    <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dout_q    <= dout_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_we   = 1'b0;
    // Single read port: the pre-fetch for the next read byte normally
    // targets ptr+1; during the command byte it looks up the new address.
    rd_addr   = ptr_q + ONE_A;

    unique case (state_q)
      IDLE: begin
        dout_d = status_i;
        if (!ss) begin
          state_d = CMD;
        end
      end

      CMD: begin
        dout_d  = status_i;
        rd_addr = spi_din[ADDR_W-1:0];
        if (byte_vld) begin
          ptr_d = spi_din[ADDR_W-1:0];
          if (spi_din[CMD_WRITE_BIT]) begin
            state_d = WR;
            dout_d  = 8'h00;
          end else begin
            state_d = RD;
            dout_d  = rd_data;
          end
        end
      end

      WR: begin
        dout_d = 8'h00;
        if (byte_vld) begin
          if (ptr_in_range) begin
            bank_we   = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = spi_din;
          end
          ptr_d = ptr_q + ONE_A;
        end
      end

      RD: begin
        if (byte_vld) begin
          ptr_d  = ptr_q + ONE_A;
          dout_d = rd_data;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect overrides every state transition.
    if (ss) begin
      state_d = IDLE;
    end
  end

  assign spi_dout = dout_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: framing, bursts, range/wrap, abort, back-to-back, async reset.
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: n/a.
module tb_spi_reg_ctrl;

  localparam int NREGS = 8;

  logic               clk;
  logic               rst;
  logic               ss;
  logic [7:0]         spi_din;
  logic               spi_done;
  logic [7:0]         spi_dout;
  logic [7:0]         status_i;
  logic [8*NREGS-1:0] regs_o;
  logic               wr_stb;
  logic [6:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               busy;

  int checks;
  int failures;
  int stb_cnt;
  int base;
  logic [8*NREGS-1:0] exp_regs;

  spi_reg_ctrl #(
    .NREGS   (NREGS),
    .RST_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .spi_din  (spi_din),
    .spi_done (spi_done),
    .spi_dout (spi_dout),
    .status_i (status_i),
    .regs_o   (regs_o),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count write strobes shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (wr_stb === 1'b1) stb_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    spi_din  = b;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
  endtask

  task automatic ss_end();
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (spi_dout !== 8'h00) begin failures++; $display("FAIL rst_dout: got %h want 00", spi_dout); end
    checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL rst_stb: got %b want 0", wr_stb); end
    checks++; if (wr_addr !== 7'h00 || wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr: got %h/%h want 00/00", wr_addr, wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (regs_o !== 64'h0) begin failures++; $display("FAIL rst_regs: got %h want 0", regs_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (spi_dout !== 8'hA5) begin failures++; $display("FAIL idle_status: got %h want a5", spi_dout); end
  endtask

  task automatic test_write_burst();
    base = stb_cnt;
    ss_begin();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b want 1", busy); end
    checks++; if (spi_dout !== 8'hA5) begin failures++; $display("FAIL wr_cmd_status: got %h want a5", spi_dout); end
    send_byte(8'h81);
    checks++; if (spi_dout !== 8'h00 || wr_stb !== 1'b0) begin failures++; $display("FAIL wr_after_cmd: got dout=%h stb=%b want 00/0", spi_dout, wr_stb); end
    send_byte(8'h12);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h01, 8'h12}) begin failures++; $display("FAIL wr_stb1: got %b/%h/%h want 1/01/12", wr_stb, wr_addr, wr_data); end
    exp_regs[15:8] = 8'h12;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL wr_regs1: got %h want %h", regs_o, exp_regs); end
    send_byte(8'h34);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h02, 8'h34}) begin failures++; $display("FAIL wr_stb2: got %b/%h/%h want 1/02/34", wr_stb, wr_addr, wr_data); end
    exp_regs[23:16] = 8'h34;
    ss_end();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_drop: got %b want 0", busy); end
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL wr_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 2) begin failures++; $display("FAIL wr_stb_count: got %0d want 2", stb_cnt - base); end
  endtask

  task automatic test_read_burst();
    base = stb_cnt;
    status_i = 8'h5A;
    ss_begin();
    checks++; if (spi_dout !== 8'h5A) begin failures++; $display("FAIL rd_cmd_status: got %h want 5a", spi_dout); end
    send_byte(8'h01);
    checks++; if (spi_dout !== 8'h12) begin failures++; $display("FAIL rd_first: got %h want 12", spi_dout); end
    send_byte(8'hFF);
    checks++; if (spi_dout !== 8'h34) begin failures++; $display("FAIL rd_second: got %h want 34", spi_dout); end
    send_byte(8'hFF);
    checks++; if (spi_dout !== 8'h00) begin failures++; $display("FAIL rd_third: got %h want 00", spi_dout); end
    ss_end();
    checks++; if (stb_cnt - base !== 0) begin failures++; $display("FAIL rd_no_stb: got %0d want 0", stb_cnt - base); end
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL rd_regs: got %h want %h", regs_o, exp_regs); end
  endtask

  task automatic test_wrap();
    base = stb_cnt;
    ss_begin();
    send_byte(8'hFF);
    send_byte(8'h55);
    checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL wrap_7f_stb: got %b want 0", wr_stb); end
    send_byte(8'h66);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h00, 8'h66}) begin failures++; $display("FAIL wrap_stb: got %b/%h/%h want 1/00/66", wr_stb, wr_addr, wr_data); end
    ss_end();
    exp_regs[7:0] = 8'h66;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL wrap_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 1) begin failures++; $display("FAIL wrap_stb_count: got %0d want 1", stb_cnt - base); end
  endtask

  task automatic test_out_of_range();
    base = stb_cnt;
    status_i = 8'hC3;
    ss_begin();
    send_byte(8'h86);
    send_byte(8'hAA);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h06, 8'hAA}) begin failures++; $display("FAIL oor_stb6: got %b/%h/%h want 1/06/aa", wr_stb, wr_addr, wr_data); end
    send_byte(8'hBB);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h07, 8'hBB}) begin failures++; $display("FAIL oor_stb7: got %b/%h/%h want 1/07/bb", wr_stb, wr_addr, wr_data); end
    send_byte(8'hCC);
    checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL oor_stb8: got %b want 0", wr_stb); end
    ss_end();
    exp_regs[55:48] = 8'hAA;
    exp_regs[63:56] = 8'hBB;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL oor_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 2) begin failures++; $display("FAIL oor_stb_count: got %0d want 2", stb_cnt - base); end
    ss_begin();
    send_byte(8'h08);
    checks++; if (spi_dout !== 8'h00) begin failures++; $display("FAIL oor_rd8: got %h want 00", spi_dout); end
    send_byte(8'hFF);
    checks++; if (spi_dout !== 8'h00) begin failures++; $display("FAIL oor_rd9: got %h want 00", spi_dout); end
    ss_end();
  endtask

  task automatic test_abort();
    base = stb_cnt;
    ss_begin();
    send_byte(8'h83);
    @(negedge clk);
    spi_din  = 8'h77;
    spi_done = 1'b1;
    ss       = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checks++; if (wr_stb !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_state: got stb=%b busy=%b want 0/0", wr_stb, busy); end
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL abort_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 0) begin failures++; $display("FAIL abort_stb_count: got %0d want 0", stb_cnt - base); end
    ss_begin();
    send_byte(8'h01);
    checks++; if (spi_dout !== 8'h12) begin failures++; $display("FAIL abort_fresh_cmd: got %h want 12", spi_dout); end
    ss_end();
  endtask

  task automatic test_back_to_back();
    base = stb_cnt;
    ss_begin();
    @(negedge clk);
    spi_din  = 8'h83;
    spi_done = 1'b1;
    @(negedge clk);
    spi_din  = 8'h9A;
    @(negedge clk);
    spi_din  = 8'h9B;
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h03, 8'h9A}) begin failures++; $display("FAIL b2b_stb3: got %b/%h/%h want 1/03/9a", wr_stb, wr_addr, wr_data); end
    @(negedge clk);
    spi_done = 1'b0;
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h04, 8'h9B}) begin failures++; $display("FAIL b2b_stb4: got %b/%h/%h want 1/04/9b", wr_stb, wr_addr, wr_data); end
    ss_end();
    exp_regs[31:24] = 8'h9A;
    exp_regs[39:32] = 8'h9B;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL b2b_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 2) begin failures++; $display("FAIL b2b_stb_count: got %0d want 2", stb_cnt - base); end
    ss_begin();
    @(negedge clk);
    spi_din  = 8'h03;
    spi_done = 1'b1;
    @(negedge clk);
    spi_din  = 8'hFF;
    checks++; if (spi_dout !== 8'h9A) begin failures++; $display("FAIL b2b_rd3: got %h want 9a", spi_dout); end
    @(negedge clk);
    checks++; if (spi_dout !== 8'h9B) begin failures++; $display("FAIL b2b_rd4: got %h want 9b", spi_dout); end
    @(negedge clk);
    spi_done = 1'b0;
    checks++; if (spi_dout !== 8'h00) begin failures++; $display("FAIL b2b_rd5: got %h want 00", spi_dout); end
    ss_end();
  endtask

  task automatic test_async_reset();
    ss_begin();
    send_byte(8'h81);
    send_byte(8'h11);
    exp_regs[15:8] = 8'h11;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL ar_pre_regs: got %h want %h", regs_o, exp_regs); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_regs = '0;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL ar_regs: got %h want 0", regs_o); end
    checks++; if (spi_dout !== 8'h00 || busy !== 1'b0 || wr_stb !== 1'b0) begin failures++; $display("FAIL ar_outs: got dout=%h busy=%b stb=%b want 00/0/0", spi_dout, busy, wr_stb); end
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = stb_cnt;
    ss_begin();
    send_byte(8'h82);
    send_byte(8'h44);
    checks++; if ({wr_stb, wr_addr, wr_data} !== {1'b1, 7'h02, 8'h44}) begin failures++; $display("FAIL ar_resume_stb: got %b/%h/%h want 1/02/44", wr_stb, wr_addr, wr_data); end
    ss_end();
    exp_regs[23:16] = 8'h44;
    checks++; if (regs_o !== exp_regs) begin failures++; $display("FAIL ar_resume_regs: got %h want %h", regs_o, exp_regs); end
    checks++; if (stb_cnt - base !== 1) begin failures++; $display("FAIL ar_stb_count: got %0d want 1", stb_cnt - base); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    stb_cnt  = 0;
    base     = 0;
    exp_regs = '0;
    rst      = 1'b0;
    ss       = 1'b1;
    spi_din  = 8'h00;
    spi_done = 1'b0;
    status_i = 8'hA5;

    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
